// File: rtl/button_debounce_multi_pkg.sv
// Shared types and helpers for the multi-channel push-button front end.
package button_debounce_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_t;

    // Polarity helper: returns 1 when the raw pin level means "pressed".
    function automatic logic normalise(input logic raw, input logic active_low);
        return raw ^ active_low;
    endfunction

    // Hold counter width: must reach the larger of the two thresholds without wrapping.
    function automatic int hold_width(input int long_cyc, input int repeat_cyc);
        int m;
        m = (long_cyc > repeat_cyc) ? long_cyc : repeat_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debouncer, hold FSM and four one-cycle strobes.
module btn_channel
    import button_debounce_multi_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 16,
    parameter int LONG_CYC     = 1000,
    parameter int REPEAT_CYC   = 200,
    parameter int REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic ACT_LOW  = (ACTIVE_LOW != 0);
    localparam logic IDLE_RAW = ACT_LOW;
    localparam int   DEB_W    = $clog2(DEBOUNCE_CYC);
    localparam int   HOLD_W   = hold_width(LONG_CYC, REPEAT_CYC);

    logic              sync1;
    logic              sync2;
    logic              pressed;
    logic [DEB_W-1:0]  deb_cnt;
    logic              change;
    logic              press_evt;
    logic              rel_evt;
    hold_state_t       state;
    hold_state_t       next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold_cnt;
    logic              long_set;
    logic              repeat_set;

    // Synchroniser flops come out of reset at the "released" pin level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign pressed   = normalise(sync2, ACT_LOW);
    assign change    = (pressed != level) && (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1));
    assign press_evt = change & pressed;
    assign rel_evt   = change & ~pressed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= press_evt;
            release_pulse <= rel_evt;
            if (pressed == level) begin
                deb_cnt <= '0;
            end else if (change) begin
                level   <= pressed;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= next_hold_cnt;
            long_pulse   <= long_set;
            repeat_pulse <= repeat_set;
        end
    end

    // A release event always beats a long/repeat threshold landing on the same cycle.
    always_comb begin
        next_state    = state;
        next_hold_cnt = hold_cnt;
        long_set      = 1'b0;
        repeat_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                next_hold_cnt = '0;
                if (press_evt) next_state = ST_HELD;
            end
            ST_HELD: begin
                if (rel_evt) begin
                    next_state    = ST_IDLE;
                    next_hold_cnt = '0;
                end else if (hold_cnt == HOLD_W'(LONG_CYC - 1)) begin
                    next_state    = ST_LONG;
                    next_hold_cnt = '0;
                    long_set      = 1'b1;
                end else begin
                    next_hold_cnt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (rel_evt) begin
                    next_state    = ST_IDLE;
                    next_hold_cnt = '0;
                end else if (REPEAT_EN != 0) begin
                    if (hold_cnt == HOLD_W'(REPEAT_CYC - 1)) begin
                        next_hold_cnt = '0;
                        repeat_set    = 1'b1;
                    end else begin
                        next_hold_cnt = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                next_state    = ST_IDLE;
                next_hold_cnt = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_debounce_multi.sv
// N independent push-button channels: debounced level plus press/release/long/repeat strobes.
module button_debounce_multi
    import button_debounce_multi_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 16,
    parameter int LONG_CYC     = 1000,
    parameter int REPEAT_CYC   = 200,
    parameter int REPEAT_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi: 2 active-low channels, short debounce/long/repeat times.
module tb_button_debounce_multi;

    localparam int SEL_PRESS = 0;
    localparam int SEL_REL   = 1;
    localparam int SEL_LONG  = 2;
    localparam int SEL_REP   = 3;
    localparam int SEL_LEVEL = 4;

    logic       clk;
    logic       reset;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic [1:0] repeat_pulse;

    int errors = 0;
    int checks = 0;
    int longCount0 = 0;
    int longBefore;

    button_debounce_multi #(
        .N_BTN        (2),
        .ACTIVE_LOW   (1),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .REPEAT_CYC   (8),
        .REPEAT_EN    (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (long_pulse[0]) longCount0++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [1:0] getOut(input int sel);
        case (sel)
            SEL_PRESS: return press_pulse;
            SEL_REL:   return release_pulse;
            SEL_LONG:  return long_pulse;
            SEL_REP:   return repeat_pulse;
            default:   return level;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Button changes land on a falling edge so the next rising edge is the sampling edge.
    task automatic applyStimulus(input logic [1:0] b);
        @(negedge clk);
        btn = b;
    endtask

    task automatic expectPulse(input string tag, input int sel, input int hit,
                               input logic [1:0] val, input int span);
        for (int e = 1; e <= span; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s@%0d", tag, e), getOut(sel), (e == hit) ? val : 2'b00);
        end
    endtask

    initial begin
        reset = 1'b0;
        btn   = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", level, 2'b00);
        checkOutput("rst_press", press_pulse, 2'b00);
        checkOutput("rst_release", release_pulse, 2'b00);
        checkOutput("rst_long", long_pulse, 2'b00);
        checkOutput("rst_repeat", repeat_pulse, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        // Basic press then release on channel 0
        applyStimulus(2'b10);
        expectPulse("t1_press", SEL_PRESS, 6, 2'b01, 7);
        checkOutput("t1_level_on", level, 2'b01);
        applyStimulus(2'b11);
        expectPulse("t1_release", SEL_REL, 6, 2'b01, 7);
        checkOutput("t1_level_off", level, 2'b00);

        // Three-cycle glitches on channel 1 are filtered out
        for (int g = 0; g < 3; g++) begin
            applyStimulus(2'b01);
            expectPulse("t2_glitch_lo", SEL_PRESS, 0, 2'b00, 3);
            applyStimulus(2'b11);
            expectPulse("t2_glitch_hi", SEL_PRESS, 0, 2'b00, 8);
            checkOutput("t2_level", level, 2'b00);
        end

        // Long hold, repeats, then release exactly on a repeat threshold
        longBefore = longCount0;
        applyStimulus(2'b10);
        expectPulse("t3_press", SEL_PRESS, 6, 2'b01, 6);
        expectPulse("t3_long", SEL_LONG, 20, 2'b01, 20);
        for (int r = 0; r < 3; r++) expectPulse("t3_repeat", SEL_REP, 8, 2'b01, 8);
        expectPulse("t6_quiet", SEL_REP, 0, 2'b00, 2);
        applyStimulus(2'b11);
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t6_release@%0d", e), release_pulse, (e == 6) ? 2'b01 : 2'b00);
            checkOutput($sformatf("t6_norepeat@%0d", e), repeat_pulse, 2'b00);
        end
        checkOutput("t3_level_off", level, 2'b00);
        checkOutput("t3_one_long", 2'(longCount0 - longBefore), 2'd1);

        // Simultaneous press; releasing channel 1 leaves channel 0 timing intact
        applyStimulus(2'b00);
        expectPulse("t4_press", SEL_PRESS, 6, 2'b11, 6);
        checkOutput("t4_level_both", level, 2'b11);
        expectPulse("t4_nolong", SEL_LONG, 0, 2'b00, 4);
        applyStimulus(2'b10);
        expectPulse("t4_release1", SEL_REL, 6, 2'b10, 6);
        checkOutput("t4_level_one", level, 2'b01);
        expectPulse("t4_long0", SEL_LONG, 10, 2'b01, 10);
        expectPulse("t4_repeat0", SEL_REP, 8, 2'b01, 8);
        applyStimulus(2'b11);
        expectPulse("t4_release0", SEL_REL, 6, 2'b01, 8);

        // Reset while in LONG clears immediately; a still-held button is re-detected
        applyStimulus(2'b10);
        expectPulse("t5_press", SEL_PRESS, 6, 2'b01, 6);
        expectPulse("t5_long", SEL_LONG, 20, 2'b01, 20);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_level", level, 2'b00);
        checkOutput("t5_rst_long", long_pulse, 2'b00);
        checkOutput("t5_rst_press", press_pulse, 2'b00);
        checkOutput("t5_rst_repeat", repeat_pulse, 2'b00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expectPulse("t5_repress", SEL_PRESS, 6, 2'b01, 6);
        expectPulse("t5_relong", SEL_LONG, 20, 2'b01, 20);
        applyStimulus(2'b11);
        expectPulse("t5_release", SEL_REL, 6, 2'b01, 8);
        checkOutput("t5_level_off", level, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
